// File: rtl/ps2_mouse_packetizer_if.sv
// Bus between the PS/2 mouse packetizer, its transceiver and the host register block.
// The packetizer takes the master modport; the transceiver/host model takes the slave modport.
interface ps2_mouse_packetizer_if;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       command_was_sent;
  logic       error_communication_timed_out;
  logic [7:0] the_command;
  logic       send_command;
  logic       mouse_ready;
  logic       pkt_valid;
  logic       btn_left;
  logic       btn_right;
  logic       btn_middle;
  logic [8:0] dx;
  logic [8:0] dy;
  logic       x_ovf;
  logic       y_ovf;
  logic       sync_err;

  modport master (
    input  received_data,
    input  received_data_en,
    input  command_was_sent,
    input  error_communication_timed_out,
    output the_command,
    output send_command,
    output mouse_ready,
    output pkt_valid,
    output btn_left,
    output btn_right,
    output btn_middle,
    output dx,
    output dy,
    output x_ovf,
    output y_ovf,
    output sync_err
  );

  modport slave (
    output received_data,
    output received_data_en,
    output command_was_sent,
    output error_communication_timed_out,
    input  the_command,
    input  send_command,
    input  mouse_ready,
    input  pkt_valid,
    input  btn_left,
    input  btn_right,
    input  btn_middle,
    input  dx,
    input  dy,
    input  x_ovf,
    input  y_ovf,
    input  sync_err
  );
endinterface

// File: rtl/ps2_mouse_packetizer.sv
// PS/2 mouse controller: runs reset/enable-reporting init, then assembles 3-byte
// movement packets into a registered record with a single-cycle valid strobe.
module ps2_mouse_packetizer #(
  parameter int                  TIMEOUT_W      = 20,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 20'd1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  ps2_mouse_packetizer_if.master bus
);

  typedef enum logic [3:0] {
    S_SEND_RST     = 4'd0,
    S_WAIT_RST_ACK = 4'd1,
    S_WAIT_BAT     = 4'd2,
    S_WAIT_ID      = 4'd3,
    S_SEND_EN      = 4'd4,
    S_WAIT_EN_ACK  = 4'd5,
    S_B0           = 4'd6,
    S_B1           = 4'd7,
    S_B2           = 4'd8,
    S_RESTART      = 4'd9
  } state_t;

  state_t               r_state;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [7:0]           r_b0;
  logic [7:0]           r_b1;
  logic [7:0]           r_the_command;
  logic                 r_send_command;
  logic                 r_mouse_ready;
  logic                 r_pkt_valid;
  logic                 r_btn_left;
  logic                 r_btn_right;
  logic                 r_btn_middle;
  logic [8:0]           r_dx;
  logic [8:0]           r_dy;
  logic                 r_x_ovf;
  logic                 r_y_ovf;
  logic                 r_sync_err;

  wire w_timed_out = (r_cnt >= TIMEOUT_CYCLES);

  function automatic logic [7:0] f_expected_byte(input state_t s);
    case (s)
      S_WAIT_RST_ACK: f_expected_byte = 8'hFA;
      S_WAIT_BAT:     f_expected_byte = 8'hAA;
      S_WAIT_ID:      f_expected_byte = 8'h00;
      S_WAIT_EN_ACK:  f_expected_byte = 8'hFA;
      default:        f_expected_byte = 8'h00;
    endcase
  endfunction

  function automatic state_t f_wait_next(input state_t s);
    case (s)
      S_WAIT_RST_ACK: f_wait_next = S_WAIT_BAT;
      S_WAIT_BAT:     f_wait_next = S_WAIT_ID;
      S_WAIT_ID:      f_wait_next = S_SEND_EN;
      S_WAIT_EN_ACK:  f_wait_next = S_B0;
      default:        f_wait_next = S_RESTART;
    endcase
  endfunction

  // Init/stream FSM with timeout counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_SEND_RST;
      r_cnt          <= '0;
      r_b0           <= 8'h00;
      r_b1           <= 8'h00;
      r_the_command  <= 8'h00;
      r_send_command <= 1'b0;
      r_mouse_ready  <= 1'b0;
      r_pkt_valid    <= 1'b0;
      r_btn_left     <= 1'b0;
      r_btn_right    <= 1'b0;
      r_btn_middle   <= 1'b0;
      r_dx           <= 9'h000;
      r_dy           <= 9'h000;
      r_x_ovf        <= 1'b0;
      r_y_ovf        <= 1'b0;
      r_sync_err     <= 1'b0;
    end else begin
      r_pkt_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      case (r_state)
        S_SEND_RST, S_SEND_EN: begin
          r_cnt         <= '0;
          r_mouse_ready <= 1'b0;
          // Acks only count once our request is visible; error beats success.
          if (r_send_command && bus.error_communication_timed_out) begin
            r_send_command <= 1'b0;
            r_state        <= S_RESTART;
          end else if (r_send_command && bus.command_was_sent) begin
            r_send_command <= 1'b0;
            r_state        <= (r_state == S_SEND_RST) ? S_WAIT_RST_ACK : S_WAIT_EN_ACK;
          end else begin
            r_send_command <= 1'b1;
            r_the_command  <= (r_state == S_SEND_RST) ? 8'hFF : 8'hF4;
          end
        end

        S_WAIT_RST_ACK, S_WAIT_BAT, S_WAIT_ID, S_WAIT_EN_ACK: begin
          r_send_command <= 1'b0;
          if (bus.received_data_en) begin
            r_cnt <= '0;
            if (bus.received_data == f_expected_byte(r_state)) begin
              r_state       <= f_wait_next(r_state);
              r_mouse_ready <= (r_state == S_WAIT_EN_ACK);
            end else begin
              r_state       <= S_RESTART;
              r_mouse_ready <= 1'b0;
            end
          end else if (w_timed_out) begin
            r_cnt         <= '0;
            r_state       <= S_RESTART;
            r_mouse_ready <= 1'b0;
          end else begin
            r_cnt         <= r_cnt + 1'b1;
            r_mouse_ready <= 1'b0;
          end
        end

        S_B0: begin
          r_cnt          <= '0;
          r_send_command <= 1'b0;
          r_mouse_ready  <= 1'b1;
          if (bus.received_data_en) begin
            if (bus.received_data[3]) begin
              r_b0    <= bus.received_data;
              r_state <= S_B1;
            end else begin
              r_sync_err <= 1'b1;
            end
          end else begin
            r_state <= S_B0;
          end
        end

        S_B1: begin
          r_send_command <= 1'b0;
          r_mouse_ready  <= 1'b1;
          if (bus.received_data_en) begin
            r_cnt   <= '0;
            r_b1    <= bus.received_data;
            r_state <= S_B2;
          end else if (w_timed_out) begin
            r_cnt   <= '0;
            r_state <= S_B0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_B2: begin
          r_send_command <= 1'b0;
          r_mouse_ready  <= 1'b1;
          if (bus.received_data_en) begin
            r_cnt        <= '0;
            r_btn_left   <= r_b0[0];
            r_btn_right  <= r_b0[1];
            r_btn_middle <= r_b0[2];
            r_dx         <= {r_b0[4], r_b1};
            r_dy         <= {r_b0[5], bus.received_data};
            r_x_ovf      <= r_b0[6];
            r_y_ovf      <= r_b0[7];
            r_pkt_valid  <= 1'b1;
            r_state      <= S_B0;
          end else if (w_timed_out) begin
            r_cnt   <= '0;
            r_state <= S_B0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_RESTART: begin
          // One guaranteed low cycle on send_command before the next request.
          r_cnt          <= '0;
          r_send_command <= 1'b0;
          r_mouse_ready  <= 1'b0;
          r_state        <= S_SEND_RST;
        end

        default: begin
          r_cnt          <= '0;
          r_send_command <= 1'b0;
          r_mouse_ready  <= 1'b0;
          r_state        <= S_RESTART;
        end
      endcase
    end
  end

  assign bus.the_command  = r_the_command;
  assign bus.send_command = r_send_command;
  assign bus.mouse_ready  = r_mouse_ready;
  assign bus.pkt_valid    = r_pkt_valid;
  assign bus.btn_left     = r_btn_left;
  assign bus.btn_right    = r_btn_right;
  assign bus.btn_middle   = r_btn_middle;
  assign bus.dx           = r_dx;
  assign bus.dy           = r_dy;
  assign bus.x_ovf        = r_x_ovf;
  assign bus.y_ovf        = r_y_ovf;
  assign bus.sync_err     = r_sync_err;

endmodule
